// File: rtl/dmem_rmw_ctrl.sv
// Memory-side responder for lane-aligned data-memory requests driving a word-only sync RAM.
// Partial stores merge via read-modify-write; full-word stores write directly; loads return words.
module dmem_rmw_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [3:0]        req_we,
   input  logic [31:0]       req_wdata,
   input  logic              req_rd,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned CntW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StRdWait, StWrite, StResp} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [3:0]        we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              ren_q, ren_d;
   logic              wen_q, wen_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   // Byte-address bits outside the word address are don't-care.
   logic unused_addr;
   assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   function automatic logic [31:0] merge(input logic [3:0] we, input logic [31:0] wd,
                                         input logic [31:0] rd);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = we[i] ? wd[8*i +: 8] : rd[8*i +: 8];
      end
      return m;
   endfunction

   assign req_ready = (state_q == StIdle) && !rst;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      addr_d       = addr_q;
      ren_d        = 1'b0;
      wen_d        = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr[ADDR_W+1:2];
               we_d    = req_we;
               wdata_d = req_wdata;
               rd_d    = req_rd;
               cnt_d   = '0;
               if (req_we == 4'hF) begin
                  state_d     = StWrite;
                  wen_d       = 1'b1;
                  mem_wdata_d = req_wdata;
               end else if (req_we != 4'h0 || req_rd) begin
                  state_d = StRdWait;
                  ren_d   = 1'b1;
               end
            end
         end
         StRdWait: begin
            // mem_rdata is valid in the last wait cycle; capture it on this edge.
            if (cnt_q == CntW'(RD_LAT)) begin
               cnt_d = '0;
               if (we_q != 4'h0) begin
                  state_d     = StWrite;
                  wen_d       = 1'b1;
                  mem_wdata_d = merge(we_q, wdata_q, mem_rdata);
               end else if (rd_q) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = mem_rdata;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWrite: state_d = StIdle;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         we_q         <= '0;
         wdata_q      <= '0;
         rd_q         <= 1'b0;
         addr_q       <= '0;
         ren_q        <= 1'b0;
         wen_q        <= 1'b0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         wdata_q      <= wdata_d;
         rd_q         <= rd_d;
         addr_q       <= addr_d;
         ren_q        <= ren_d;
         wen_q        <= wen_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_ren    = ren_q;
   assign mem_wen    = wen_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Scoreboard bench for dmem_rmw_ctrl: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3,
// each backed by a behavioural RAM; RAM strobes and responses are checked against a queue.
module tb_dmem_rmw_ctrl;

   localparam int KRen  = 0;
   localparam int KWen  = 1;
   localparam int KResp = 2;

   typedef struct {
      int          kind;
      int          cyc;
      logic [9:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic        clk;
   logic        rst        [2];
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic [31:0] req_addr   [2];
   logic [3:0]  req_we     [2];
   logic [31:0] req_wdata  [2];
   logic        req_rd     [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic [9:0]  mem_addr   [2];
   logic        mem_ren    [2];
   logic        mem_wen    [2];
   logic [31:0] mem_wdata  [2];
   logic [31:0] mem_rdata  [2];

   int  cyc = 0;
   int  n_checks = 0;
   int  n_pass = 0;
   ev_t q0[$];
   ev_t q1[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned Lat = (g == 0) ? 1 : 3;
      logic [31:0] ram  [1024];
      logic [31:0] pipe [Lat];

      dmem_rmw_ctrl #(.ADDR_W(10), .RD_LAT(Lat)) u_dut (
         .clk        (clk),
         .rst        (rst[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_addr   (req_addr[g]),
         .req_we     (req_we[g]),
         .req_wdata  (req_wdata[g]),
         .req_rd     (req_rd[g]),
         .resp_valid (resp_valid[g]),
         .resp_rdata (resp_rdata[g]),
         .mem_addr   (mem_addr[g]),
         .mem_ren    (mem_ren[g]),
         .mem_wen    (mem_wen[g]),
         .mem_wdata  (mem_wdata[g]),
         .mem_rdata  (mem_rdata[g])
      );

      always @(posedge clk) begin
         if (mem_wen[g]) ram[mem_addr[g]] <= mem_wdata[g];
         if (mem_ren[g]) pipe[0] <= ram[mem_addr[g]];
         for (int k = 1; k < Lat; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[g] = pipe[Lat-1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic void push(input int g, input int k, input int c, input logic [9:0] a,
                                input logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.addr = a;
      e.data = d;
      if (g == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   task automatic check_ev(input int g, input int k, input logic [9:0] a, input logic [31:0] d);
      ev_t e;
      bit  ok;
      n_checks++;
      if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
         $display("FAIL ev_unexpected inst%0d: kind %0d at cycle %0d, expected no event",
                  g, k, cyc);
         return;
      end
      e  = (g == 0) ? q0.pop_front() : q1.pop_front();
      ok = (e.kind == k) && (e.cyc == cyc) && (e.addr == a);
      if (k != KRen) ok = ok && (e.data === d);
      if (ok) n_pass++;
      else $display("FAIL ev inst%0d: got kind %0d cyc %0d addr %0d data 0x%08h, expected kind %0d cyc %0d addr %0d data 0x%08h",
                    g, k, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
   endtask

   // Monitor: every strobe the DUT presents must match the head of its queue.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_ren[g] === 1'b1 || mem_wen[g] === 1'b1)
            chk($sformatf("ren_wen_excl%0d", g), {31'd0, mem_ren[g] & mem_wen[g]}, 32'd0);
         if (mem_ren[g] === 1'b1) check_ev(g, KRen, mem_addr[g], 32'd0);
         if (mem_wen[g] === 1'b1) check_ev(g, KWen, mem_addr[g], mem_wdata[g]);
         if (resp_valid[g] === 1'b1) check_ev(g, KResp, mem_addr[g], resp_rdata[g]);
      end
   end

   // Drive a request, wait for acceptance, push expected events. abort drops the write.
   task automatic issue(input int g, input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] wd, input logic rd, input logic [31:0] exp_d,
                        input bit abort, output int t);
      int lat;
      int n;
      lat = (g == 0) ? 1 : 3;
      @(negedge clk);
      req_valid[g] = 1'b1;
      req_addr[g]  = addr;
      req_we[g]    = we;
      req_wdata[g] = wd;
      req_rd[g]    = rd;
      n = 0;
      while (!req_ready[g] && n < 50) begin
         @(negedge clk);
         n++;
      end
      t = cyc;
      if (!req_ready[g]) begin
         chk($sformatf("accept_timeout%0d", g), 32'd0, 32'd1);
         req_valid[g] = 1'b0;
         return;
      end
      if (we == 4'hF) begin
         push(g, KWen, t + 1, addr[11:2], wd);
      end else if (we != 4'h0) begin
         push(g, KRen, t + 1, addr[11:2], 32'd0);
         if (!abort) push(g, KWen, t + lat + 2, addr[11:2], exp_d);
      end else if (rd) begin
         push(g, KRen, t + 1, addr[11:2], 32'd0);
         push(g, KResp, t + lat + 2, addr[11:2], exp_d);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int g, input int n);
      @(negedge clk);
      req_valid[g] = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      int t2;
      for (int g = 0; g < 2; g++) begin
         rst[g] = 1'b1;
         req_valid[g] = 1'b0;
         req_addr[g] = '0;
         req_we[g] = '0;
         req_wdata[g] = '0;
         req_rd[g] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'd0, req_ready[0]}, 32'd0);
      chk("rst_strobes", {29'd0, resp_valid[0], mem_ren[0], mem_wen[0]}, 32'd0);
      chk("rst_rdata", resp_rdata[0], 32'd0);
      chk("rst_wdata", mem_wdata[0], 32'd0);
      chk("rst_addr", {22'd0, mem_addr[0]}, 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      #1;
      chk("ready_after_rst", {31'd0, req_ready[0]}, 32'd1);

      // Full store, then byte / halfword read-modify-write (RD_LAT=1).
      issue(0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, t);
      idle(0, 2);
      issue(0, 32'h10, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0, t);
      idle(0, 2);
      issue(0, 32'h10, 4'b0010, 32'h0000AB00, 1'b0, 32'h1122AB44, 1'b0, t);
      idle(0, 5);
      issue(0, 32'h10, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0, t);
      idle(0, 2);
      issue(0, 32'h10, 4'b1100, 32'hCAFE0000, 1'b0, 32'hCAFE3344, 1'b0, t);
      idle(0, 5);
      issue(0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hCAFE3344, 1'b0, t);
      idle(0, 5);

      // Load from an unaligned byte address; response data must be held.
      issue(0, 32'h1C, 4'hF, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, t);
      idle(0, 2);
      issue(0, 32'h1F, 4'h0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, t);
      idle(0, 6);
      chk("rdata_held", resp_rdata[0], 32'h0BADF00D);
      chk("resp_pulse_low", {31'd0, resp_valid[0]}, 32'd0);

      // Reset during RD_WAIT of a partial store abandons it.
      issue(0, 32'h10, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0, t);
      idle(0, 2);
      issue(0, 32'h10, 4'b0001, 32'h000000FF, 1'b0, 32'h0, 1'b1, t);
      @(negedge clk);
      rst[0] = 1'b1;
      req_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_in_rst", {31'd0, req_ready[0]}, 32'd0);
      chk("addr_after_rst", {22'd0, mem_addr[0]}, 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      #1;
      chk("ready_post_rst", {31'd0, req_ready[0]}, 32'd1);
      idle(0, 8);
      chk("ram4_kept", g_dut[0].ram[4], 32'h11223344);
      issue(0, 32'h10, 4'h0, 32'h0, 1'b1, 32'h11223344, 1'b0, t);
      idle(0, 5);

      // RD_LAT=3: back-to-back stores with req_valid held, then a no-op, then a load.
      issue(1, 32'h20, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, t);
      idle(1, 2);
      issue(1, 32'h20, 4'b0011, 32'h00001234, 1'b0, 32'hA5A51234, 1'b0, t);
      issue(1, 32'h24, 4'hF, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, t2);
      chk("b2b_accept_cycle", t2, t + 6);
      idle(1, 2);
      issue(1, 32'h28, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, t);
      @(negedge clk);
      chk("noop_ready", {31'd0, req_ready[1]}, 32'd1);
      idle(1, 4);
      issue(1, 32'h20, 4'h0, 32'h0, 1'b1, 32'hA5A51234, 1'b0, t);
      idle(1, 8);
      chk("ram9_b2b", g_dut[1].ram[9], 32'h55AA55AA);

      idle(0, 4);
      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
